// File: rtl/multi_zone_thermostat.sv
// Multi-zone hysteresis thermostat with a word-serial programming port.
// Each zone holds its own target/hysteresis and enforces a minimum dwell between heater switches.
module multi_zone_thermostat #(
    parameter int N_ZONES   = 4,
    parameter int TEMP_W    = 8,
    parameter int MIN_DWELL = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      program_i,
    input  logic [TEMP_W-1:0]         data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [N_ZONES-1:0]        zone_active_i,
    input  logic [N_ZONES*TEMP_W-1:0] temp_i,
    output logic [N_ZONES-1:0]        heater_on_o,
    output logic                      prog_busy_o,
    output logic                      prog_err_o
);
    localparam int               CNT_W      = $clog2(MIN_DWELL + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(MIN_DWELL - 1);
    localparam logic [TEMP_W:0]  ZONE_LIMIT = (TEMP_W + 1)'(N_ZONES);

    typedef enum logic [1:0] {P_IDLE, P_ZONE, P_TARGET, P_HYST} progState_e;
    typedef enum logic [1:0] {OFF, ARMED, HEAT} zoneState_e;

    progState_e        progState_q, progState_d;
    logic [TEMP_W-1:0] zoneSel_q, zoneSel_d;
    logic [TEMP_W-1:0] stagedTarget_q, stagedTarget_d;
    logic              progErr_q, progErr_d;
    logic              accept;
    logic              commit;
    logic [TEMP_W-1:0] target_q [N_ZONES];
    logic [TEMP_W-1:0] hyst_q   [N_ZONES];

    assign ready_o     = (progState_q != P_IDLE);
    assign prog_busy_o = ready_o;
    assign prog_err_o  = progErr_q;
    assign accept      = valid_i && ready_o;
    assign commit      = accept && (progState_q == P_HYST);

    always_comb begin
        progState_d    = progState_q;
        zoneSel_d      = zoneSel_q;
        stagedTarget_d = stagedTarget_q;
        progErr_d      = 1'b0;
        unique case (progState_q)
            P_IDLE: begin
                if (program_i) progState_d = P_ZONE;
            end
            P_ZONE: begin
                if (accept) begin
                    if ({1'b0, data_i} >= ZONE_LIMIT) begin
                        progErr_d   = 1'b1;
                        progState_d = P_IDLE;
                    end else begin
                        zoneSel_d   = data_i;
                        progState_d = P_TARGET;
                    end
                end
            end
            P_TARGET: begin
                if (accept) begin
                    stagedTarget_d = data_i;
                    progState_d    = P_HYST;
                end
            end
            P_HYST: begin
                if (accept) progState_d = P_IDLE;
            end
            default: progState_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            progState_q    <= P_IDLE;
            zoneSel_q      <= '0;
            stagedTarget_q <= '0;
            progErr_q      <= 1'b0;
        end else begin
            progState_q    <= progState_d;
            zoneSel_q      <= zoneSel_d;
            stagedTarget_q <= stagedTarget_d;
            progErr_q      <= progErr_d;
        end
    end

    // Commit writes only the selected zone; every other zone keeps its settings.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int z = 0; z < N_ZONES; z++) begin
                target_q[z] <= '0;
                hyst_q[z]   <= '0;
            end
        end else if (commit) begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (zoneSel_q == TEMP_W'(z)) begin
                    target_q[z] <= stagedTarget_q;
                    hyst_q[z]   <= data_i;
                end
            end
        end
    end

    for (genvar z = 0; z < N_ZONES; z++) begin : gZone
        zoneState_e        state_q, state_d;
        logic [CNT_W-1:0]  dwell_q, dwell_d;
        logic [TEMP_W:0]   diff;
        logic [TEMP_W-1:0] lowThr;
        logic [TEMP_W-1:0] temp;
        logic              dwellDone;

        assign temp      = temp_i[z*TEMP_W +: TEMP_W];
        assign diff      = {1'b0, target_q[z]} - {1'b0, hyst_q[z]};
        assign lowThr    = diff[TEMP_W] ? '0 : diff[TEMP_W-1:0];
        assign dwellDone = (dwell_q == '0);

        // Disabling a zone overrides the dwell; the counter keeps draining unless already idle.
        always_comb begin
            state_d = state_q;
            dwell_d = dwellDone ? dwell_q : dwell_q - CNT_W'(1);
            if (!zone_active_i[z]) begin
                state_d = OFF;
                if (state_q == OFF) dwell_d = '0;
            end else begin
                unique case (state_q)
                    OFF: state_d = ARMED;
                    ARMED: begin
                        if (temp < lowThr && dwellDone) begin
                            state_d = HEAT;
                            dwell_d = DWELL_LOAD;
                        end
                    end
                    HEAT: begin
                        if (temp >= target_q[z] && dwellDone) begin
                            state_d = ARMED;
                            dwell_d = DWELL_LOAD;
                        end
                    end
                    default: state_d = OFF;
                endcase
            end
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                state_q <= OFF;
                dwell_q <= '0;
            end else begin
                state_q <= state_d;
                dwell_q <= dwell_d;
            end
        end

        assign heater_on_o[z] = (state_q == HEAT);
    end
endmodule
